// File: rtl/cdc_handshake_transmitter_if.sv
// Word/handshake bundle of the toggle-based CDC transmitter.
// master = producer and destination side, slave = transmitter.
interface cdc_handshake_transmitter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] write_data;
  logic             write_valid;
  logic             write_ready;
  logic [WIDTH-1:0] cdc_data;
  logic             cdc_request;
  logic             cdc_acknowledge;
  logic             busy;

  modport master (
    output write_data,
    output write_valid,
    output cdc_acknowledge,
    input  write_ready,
    input  cdc_data,
    input  cdc_request,
    input  busy
  );

  modport slave (
    input  write_data,
    input  write_valid,
    input  cdc_acknowledge,
    output write_ready,
    output cdc_data,
    output cdc_request,
    output busy
  );
endinterface

// File: rtl/cdc_handshake_transmitter.sv
// Source side of a toggle request/acknowledge word crossing.
// CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN adds one skid word register.
module cdc_handshake_transmitter #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic                       clock,
  input logic                       reset,
  cdc_handshake_transmitter_if.slave bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [STAGES-1:0] sync_q;
  logic             ack_sync;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             req_q;
  logic             req_d;
  logic             ready;
  logic             accept;
  logic             done;

`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
  logic [WIDTH-1:0] buffer_data;
  logic [WIDTH-1:0] buffer_data_d;
  logic             buffer_valid;
  logic             buffer_valid_d;

  assign ready = ~buffer_valid;
`else
  assign ready = (state_q == IDLE);
`endif

  assign ack_sync = sync_q[STAGES-1];
  assign accept   = bus.write_valid && ready;
  assign done     = (ack_sync == req_q);

  // Resynchronize the asynchronous acknowledge toggle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.cdc_acknowledge;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // State, launched word and request toggle registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
      buffer_data  <= '0;
      buffer_valid <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
      buffer_data  <= buffer_data_d;
      buffer_valid <= buffer_valid_d;
`endif
    end
  end

  // Launch words and retire them when the acknowledge matches.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
    buffer_data_d  = buffer_data;
    buffer_valid_d = buffer_valid;
    unique case (state_q)
      IDLE: begin
        if (buffer_valid) begin
          data_d         = buffer_data;
          req_d          = ~req_q;
          buffer_valid_d = 1'b0;
          state_d        = PENDING;
        end else if (accept) begin
          data_d  = bus.write_data;
          req_d   = ~req_q;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (done) begin
          if (buffer_valid) begin
            data_d         = buffer_data;
            req_d          = ~req_q;
            buffer_valid_d = 1'b0;
          end else begin
            state_d = IDLE;
            if (accept) begin
              buffer_data_d  = bus.write_data;
              buffer_valid_d = 1'b1;
            end
          end
        end else if (accept) begin
          buffer_data_d  = bus.write_data;
          buffer_valid_d = 1'b1;
        end
      end
    endcase
`else
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = bus.write_data;
          req_d   = ~req_q;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (done) begin
          state_d = IDLE;
        end
      end
    endcase
`endif
  end

  assign bus.write_ready = ready;
  assign bus.cdc_data    = data_q;
  assign bus.cdc_request = req_q;
  assign bus.busy        = (state_q == PENDING);

endmodule

// File: tb/tb_cdc_handshake_transmitter.sv
// Bench for cdc_handshake_transmitter: vector table, model receiver,
// async reset, synchronizer depth sweep and optional buffer sequence.
module tb_cdc_handshake_transmitter;

`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic clock = 1'b0;
  logic rxclk = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;
  initial begin
    #3;
    forever #7 rxclk = ~rxclk;
  end

  logic       valid_r = 1'b0;
  logic [7:0] data_r  = 8'h00;
  logic       tb_ack  = 1'b0;
  logic       rx_ack  = 1'b0;
  logic       rx_en   = 1'b0;
  logic       rx_last = 1'b0;
  logic [7:0] rx_log[$];

  cdc_handshake_transmitter_if #(.WIDTH(8)) bus ();
  assign bus.write_data      = data_r;
  assign bus.write_valid     = valid_r;
  assign bus.cdc_acknowledge = rx_en ? rx_ack : tb_ack;

  cdc_handshake_transmitter #(.WIDTH(8), .STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic       sw_valid = 1'b0;
  logic [7:0] sw_data  = 8'h00;
  logic       sw_ack   = 1'b0;
  logic [3:0] sw_busy;
  logic [3:0] sw_ready;

  for (genvar g = 0; g < 4; g++) begin : g_sw
    cdc_handshake_transmitter_if #(.WIDTH(8)) sif ();
    assign sif.write_data      = sw_data;
    assign sif.write_valid     = sw_valid;
    assign sif.cdc_acknowledge = sw_ack;
    assign sw_busy[g]  = sif.busy;
    assign sw_ready[g] = sif.write_ready;
    cdc_handshake_transmitter #(.WIDTH(8), .STAGES(g + 1)) u_sw (
      .clock (clock),
      .reset (reset),
      .bus   (sif.slave)
    );
  end

  // Destination-domain model: log word on request toggle, mirror it back.
  always @(posedge rxclk) begin
    if (reset) begin
      rx_last = 1'b0;
      rx_ack  = 1'b0;
    end else if (rx_en && bus.cdc_request !== rx_last) begin
      rx_last = bus.cdc_request;
      rx_log.push_back(bus.cdc_data);
      rx_ack  = rx_last;
    end
  end

  int         tog_cnt  = 0;
  int         stab_err = 0;
  logic       mon_req  = 1'b0;
  logic [7:0] mon_data = 8'h00;

  // Count request toggles and flag data changes while a word is pending.
  always @(negedge clock) begin
    if (bus.cdc_request !== mon_req) tog_cnt++;
    else if (bus.busy && bus.cdc_data !== mon_data) stab_err++;
    mon_req  = bus.cdc_request;
    mon_data = bus.cdc_data;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    data_r  = w;
    valid_r = 1'b1;
    while (!bus.write_ready && n < 300) begin
      @(posedge clock); #2;
      n++;
    end
    check($sformatf("send_ready_%h", w), {31'd0, bus.write_ready}, 32'd1);
    @(posedge clock); #2;
    valid_r = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clock); #2;
      n++;
    end
    check(name, {31'd0, bus.busy}, 32'd0);
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ack;
    logic       ready;
    logic       busy;
    logic       req;
    logic [7:0] cdata;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int   base_tog;
    int   base_rx;
    logic r0;
    logic [3:0] exp_b;

    vecs[0]  = '{1'b1, 8'hA5, 1'b0, BUF,  1'b1, 1'b1, 8'hA5};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, BUF,  1'b1, 1'b1, 8'hA5};
    vecs[2]  = '{!BUF, 8'hFF, 1'b0, BUF,  1'b1, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, BUF,  1'b1, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, BUF,  1'b1, 1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, BUF,  1'b1, 1'b1, 8'hA5};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[7]  = '{1'b1, 8'h5A, 1'b1, BUF,  1'b1, 1'b0, 8'h5A};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, BUF,  1'b1, 1'b0, 8'h5A};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, BUF,  1'b1, 1'b0, 8'h5A};
    vecs[10] = '{1'b0, 8'h00, 1'b0, BUF,  1'b1, 1'b0, 8'h5A};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};

    #23 reset = 1'b0;
    @(posedge clock); #1;
    check("reset_state",
          {20'd0, bus.write_ready, bus.busy, bus.cdc_request, bus.cdc_data},
          {20'd0, 1'b1, 1'b0, 1'b0, 8'h00});
    #1;

    for (int i = 0; i < 14; i++) begin
      valid_r = vecs[i].valid;
      data_r  = vecs[i].data;
      tb_ack  = vecs[i].ack;
      @(posedge clock); #1;
      check($sformatf("vec%0d", i),
            {21'd0, bus.write_ready, bus.busy, bus.cdc_request, bus.cdc_data},
            {21'd0, vecs[i].ready, vecs[i].busy, vecs[i].req, vecs[i].cdata});
      #1;
    end

    rx_en    = 1'b1;
    base_tog = tog_cnt;
    base_rx  = rx_log.size();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    wait_idle("b2b_idle");
    check("b2b_toggles", tog_cnt - base_tog, 32'd3);
    check("b2b_count", rx_log.size() - base_rx, 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (rx_log.size() > base_rx + k)
        check($sformatf("b2b_word%0d", k), {24'd0, rx_log[base_rx + k]},
              k + 1);
    end

    data_r  = 8'h3C;
    valid_r = 1'b1;
    @(posedge clock); #1;
    check("mid_accept", {23'd0, bus.busy, bus.cdc_data}, {23'd0, 1'b1, 8'h3C});
    #1 valid_r = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset",
          {21'd0, bus.write_ready, bus.busy, bus.cdc_request, bus.cdc_data},
          {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
    #30 reset = 1'b0;
    @(posedge clock); #2;
    base_rx = rx_log.size();
    check("post_reset",
          {30'd0, bus.write_ready, bus.cdc_request}, {30'd0, 1'b1, 1'b0});
    data_r  = 8'h7E;
    valid_r = 1'b1;
    @(posedge clock); #1;
    check("post_launch",
          {22'd0, bus.busy, bus.cdc_request, bus.cdc_data},
          {22'd0, 1'b1, 1'b1, 8'h7E});
    #1 valid_r = 1'b0;
    wait_idle("post_idle");
    check("post_rx_count", rx_log.size() - base_rx, 32'd1);
    if (rx_log.size() > base_rx)
      check("post_rx_word", {24'd0, rx_log[base_rx]}, 32'h7E);

`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
    begin
      int n;
      int drops;
      tb_ack = bus.cdc_request;
      rx_en  = 1'b0;
      r0     = bus.cdc_request;
      data_r  = 8'h11;
      valid_r = 1'b1;
      @(posedge clock); #1;
      check("buf_first",
            {21'd0, bus.write_ready, bus.busy, bus.cdc_request, bus.cdc_data},
            {21'd0, 1'b1, 1'b1, ~r0, 8'h11});
      #1 data_r = 8'h22;
      @(posedge clock); #1;
      check("buf_second",
            {23'd0, bus.write_ready, bus.cdc_data}, {23'd0, 1'b0, 8'h11});
      #1 valid_r = 1'b0;
      tb_ack = ~r0;
      n = 0;
      drops = 0;
      while (bus.cdc_request !== r0 && n < 20) begin
        @(posedge clock); #1;
        if (!bus.busy) drops++;
        #1 n++;
      end
      check("buf_relaunch",
            {23'd0, bus.cdc_request, bus.cdc_data}, {23'd0, r0, 8'h22});
      check("buf_no_drop", drops, 32'd0);
      tb_ack = r0;
      wait_idle("buf_idle");
    end
`endif

    sw_data  = 8'h99;
    sw_valid = 1'b1;
    @(posedge clock); #1;
    check("sweep_accept", {28'd0, sw_busy}, {28'd0, 4'hF});
    #1 sw_valid = 1'b0;
    sw_ack = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clock); #1;
      for (int g = 0; g < 4; g++) exp_b[g] = (n <= g + 1);
      check($sformatf("sweep_edge%0d", n),
            {24'd0, sw_busy, sw_ready}, {24'd0, exp_b, ~exp_b});
      #1;
    end

    check("data_stability", stab_err, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
